// File: rtl/net2axis_arbiter.sv
// ---------------------------------------------------------------------------
// net2axis_arbiter
//
// Packet-granular round-robin arbiter. It merges C_NUM_PORTS AXI4-Stream
// sources onto one AXI4-Stream output. A port keeps the grant from the first
// beat of a packet until its TLAST transfer, so the beats of different packets
// never interleave. Each output beat is tagged with the index of its source
// port. The block also counts forwarded packets and combines the sources' DONE
// flags into a single end-of-test flag.
//
// Ports
//   ACLK, ARESETN    clock (rising edge); asynchronous active-low reset
//   S_AXIS_T*        per-port slave streams; port i uses bit i or slice i
//   S_AXIS_TREADY    per-port ready; only the granted port can be ready
//   S_DONE           per-port DONE flags from the sources
//   M_AXIS_T*        merged master stream; M_AXIS_TID is the granted port
//   M_AXIS_TREADY    downstream ready
//   PKT_COUNT        number of packets forwarded (wraps around)
//   DONE             sticky flag: all sources done and the arbiter idle
// ---------------------------------------------------------------------------
module net2axis_arbiter #(
   parameter int C_NUM_PORTS   = 4,
   parameter int C_TDATA_WIDTH = 32,
   parameter int C_CNT_WIDTH   = 16,
   localparam int TIDW = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1,
   localparam int KW   = C_TDATA_WIDTH / 8
) (
   input  logic                                 ACLK,
   input  logic                                 ARESETN,
   input  logic [C_NUM_PORTS-1:0]               S_AXIS_TVALID,
   input  logic [C_NUM_PORTS*C_TDATA_WIDTH-1:0] S_AXIS_TDATA,
   input  logic [C_NUM_PORTS*KW-1:0]            S_AXIS_TKEEP,
   input  logic [C_NUM_PORTS-1:0]               S_AXIS_TLAST,
   output logic [C_NUM_PORTS-1:0]               S_AXIS_TREADY,
   input  logic [C_NUM_PORTS-1:0]               S_DONE,
   output logic                                 M_AXIS_TVALID,
   output logic [C_TDATA_WIDTH-1:0]             M_AXIS_TDATA,
   output logic [KW-1:0]                        M_AXIS_TKEEP,
   output logic                                 M_AXIS_TLAST,
   output logic [TIDW-1:0]                      M_AXIS_TID,
   input  logic                                 M_AXIS_TREADY,
   output logic [C_CNT_WIDTH-1:0]               PKT_COUNT,
   output logic                                 DONE
);

   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

   state_t                   state, state_nxt;
   logic [TIDW-1:0]          grant, grant_nxt, last_grant;
   logic [TIDW-1:0]          req_idx, cand;
   logic                     req_found;
   logic                     last_xfer;
   logic                     done_set;
   logic [C_CNT_WIDTH-1:0]   pkt_cnt;
   logic                     done_r;
   logic [C_TDATA_WIDTH-1:0] tdata_arr [C_NUM_PORTS];
   logic [KW-1:0]            tkeep_arr [C_NUM_PORTS];

   // Unpack the flat per-port buses so the output mux is a plain array index.
   always_comb begin
      for (int i = 0; i < C_NUM_PORTS; i++) begin
         tdata_arr[i] = S_AXIS_TDATA[i*C_TDATA_WIDTH +: C_TDATA_WIDTH];
         tkeep_arr[i] = S_AXIS_TKEEP[i*KW +: KW];
      end
   end

   // Round-robin search: first requesting port after the last one served.
   // The last candidate examined is last_grant itself, so a lone requester
   // is always found.
   always_comb begin
      req_found = 1'b0;
      req_idx   = last_grant;
      cand      = '0;
      for (int k = 1; k <= C_NUM_PORTS; k++) begin
         cand = TIDW'((int'(last_grant) + k) % C_NUM_PORTS);
         if (!req_found && S_AXIS_TVALID[cand]) begin
            req_found = 1'b1;
            req_idx   = cand;
         end
      end
   end

   // Data path is a pure mux: no buffering, zero latency while granted.
   // Outside XFER the mux still shows the granted port, only TVALID is gated.
   assign M_AXIS_TDATA = tdata_arr[grant];
   assign M_AXIS_TKEEP = tkeep_arr[grant];
   assign M_AXIS_TLAST = S_AXIS_TLAST[grant];
   assign M_AXIS_TID   = grant;
   assign PKT_COUNT    = pkt_cnt;
   assign DONE         = done_r;

   assign last_xfer = (state == XFER) && S_AXIS_TVALID[grant] &&
                      M_AXIS_TREADY && S_AXIS_TLAST[grant];
   assign done_set  = (&S_DONE) && (state == IDLE) && !(|S_AXIS_TVALID);

   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant;
      M_AXIS_TVALID = 1'b0;
      S_AXIS_TREADY = '0;
      case (state)
         IDLE: begin
            // One arbitration cycle per packet; the selected port's first
            // beat appears on the next cycle.
            if (req_found) begin
               state_nxt = XFER;
               grant_nxt = req_idx;
            end
         end
         XFER: begin
            // A source bubble mid-packet is passed through; the grant holds.
            M_AXIS_TVALID        = S_AXIS_TVALID[grant];
            S_AXIS_TREADY[grant] = M_AXIS_TREADY;
            if (last_xfer) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state      <= IDLE;
         grant      <= '0;
         // Start as if the highest port was served last, so port 0 wins first.
         last_grant <= TIDW'(C_NUM_PORTS - 1);
         pkt_cnt    <= '0;
         done_r     <= 1'b0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         if (last_xfer) begin
            last_grant <= grant;
            pkt_cnt    <= pkt_cnt + C_CNT_WIDTH'(1);
         end
         if (done_set) begin
            done_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_net2axis_arbiter.sv
module tb_net2axis_arbiter;

   logic          ACLK = 1'b0;
   logic          ARESETN;
   logic [3:0]    S_TVALID, S_TLAST, S_DONE;
   logic [127:0]  S_TDATA;
   logic [15:0]   S_TKEEP;
   logic          M_TREADY;
   wire  [3:0]    S_TREADY, w_TREADY;
   wire           M_TVALID, M_TLAST, w_TVALID, w_TLAST;
   wire  [31:0]   M_TDATA, w_TDATA;
   wire  [3:0]    M_TKEEP, w_TKEEP;
   wire  [1:0]    M_TID, w_TID;
   wire  [15:0]   PKT_COUNT;
   wire  [1:0]    w_COUNT;
   wire           DONE, w_DONE;

   int n_tests = 0;
   int n_fail  = 0;

   net2axis_arbiter #(.C_NUM_PORTS(4), .C_TDATA_WIDTH(32), .C_CNT_WIDTH(16)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AXIS_TVALID(S_TVALID), .S_AXIS_TDATA(S_TDATA), .S_AXIS_TKEEP(S_TKEEP),
      .S_AXIS_TLAST(S_TLAST), .S_AXIS_TREADY(S_TREADY), .S_DONE(S_DONE),
      .M_AXIS_TVALID(M_TVALID), .M_AXIS_TDATA(M_TDATA), .M_AXIS_TKEEP(M_TKEEP),
      .M_AXIS_TLAST(M_TLAST), .M_AXIS_TID(M_TID), .M_AXIS_TREADY(M_TREADY),
      .PKT_COUNT(PKT_COUNT), .DONE(DONE));

   // Narrow-counter instance sharing the same stimulus, for the wrap check.
   net2axis_arbiter #(.C_NUM_PORTS(4), .C_TDATA_WIDTH(32), .C_CNT_WIDTH(2)) dut_w (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AXIS_TVALID(S_TVALID), .S_AXIS_TDATA(S_TDATA), .S_AXIS_TKEEP(S_TKEEP),
      .S_AXIS_TLAST(S_TLAST), .S_AXIS_TREADY(w_TREADY), .S_DONE(S_DONE),
      .M_AXIS_TVALID(w_TVALID), .M_AXIS_TDATA(w_TDATA), .M_AXIS_TKEEP(w_TKEEP),
      .M_AXIS_TLAST(w_TLAST), .M_AXIS_TID(w_TID), .M_AXIS_TREADY(M_TREADY),
      .PKT_COUNT(w_COUNT), .DONE(w_DONE));

   always #5 ACLK = ~ACLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0]  vld;
      logic [3:0]  lst;
      logic [7:0]  d;
      logic        mrdy;
      logic [3:0]  sdone;
      logic        ev;
      logic [31:0] ed;
      logic        el;
      logic [1:0]  etid;
      logic [3:0]  erdy;
      int          ecnt;
      logic        edone;
   } vec_t;

   typedef struct {
      int port;
      int pkt;
   } exp_t;

   vec_t tbl[$];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(logic [3:0] vld, logic [3:0] lst, logic [7:0] d, logic mrdy,
                               logic [3:0] sdone, logic ev, logic [31:0] ed, logic el,
                               logic [1:0] etid, logic [3:0] erdy, int ecnt, logic edone);
      vec_t v;
      v.vld = vld; v.lst = lst; v.d = d; v.mrdy = mrdy; v.sdone = sdone; v.ev = ev;
      v.ed = ed; v.el = el; v.etid = etid; v.erdy = erdy; v.ecnt = ecnt; v.edone = edone;
      return v;
   endfunction

   function automatic logic [31:0] src_data(int p, int k, int b);
      return {8'(p), 8'(k), 8'(b), 8'h5A};
   endfunction

   function automatic logic [3:0] src_keep(int p, int b);
      return 4'(p + b) | 4'b0001;
   endfunction

   task automatic reset_dut();
      ARESETN = 1'b0;
      S_TVALID = '0; S_TLAST = '0; S_TDATA = '0; S_TKEEP = '0; S_DONE = '0; M_TREADY = 1'b0;
      repeat (2) @(posedge ACLK);
      #1 ARESETN = 1'b1;
   endtask

   // Packet-level reference: each port owns a list of packets; the expected
   // output order is rebuilt by walking ports round-robin over those still
   // holding packets, and every beat is compared with the source's content.
   task automatic run_traffic(input bit rnd, input string tag);
      int npk[4];
      int plen[4][8];
      int rem[4];
      int cur_pkt[4];
      int cur_beat[4];
      exp_t expq[$];
      exp_t e;
      int last, total, pi, bi;
      bit gap, fin, exp_last;
      logic [3:0] shs;
      reset_dut();
      total = 0;
      for (int p = 0; p < 4; p++) begin
         npk[p] = rnd ? int'($urandom_range(1, 4)) : 2;
         for (int k = 0; k < 8; k++) plen[p][k] = rnd ? int'($urandom_range(1, 4)) : 2;
         rem[p] = npk[p]; cur_pkt[p] = 0; cur_beat[p] = 0;
         total += npk[p];
      end
      last = 3;
      for (int t = 0; t < total; t++) begin
         for (int k = 1; k <= 4; k++) begin
            int q;
            q = (last + k) % 4;
            if (rem[q] > 0) begin
               e.port = q; e.pkt = npk[q] - rem[q];
               expq.push_back(e);
               rem[q]--; last = q;
               break;
            end
         end
      end
      pi = 0; bi = 0; gap = 0; fin = 0;
      for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
         for (int p = 0; p < 4; p++) begin
            if (cur_pkt[p] < npk[p]) begin
               S_TVALID[p] = (cur_beat[p] == 0 || !rnd) ? 1'b1 : ($urandom_range(0, 3) != 0);
               S_TDATA[p*32 +: 32] = src_data(p, cur_pkt[p], cur_beat[p]);
               S_TKEEP[p*4 +: 4]   = src_keep(p, cur_beat[p]);
               S_TLAST[p] = (cur_beat[p] == plen[p][cur_pkt[p]] - 1);
            end else begin
               S_TVALID[p] = 1'b0;
               S_TLAST[p]  = 1'b0;
            end
         end
         M_TREADY = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         @(negedge ACLK);
         check({tag, " ready onehot"}, 64'(S_TREADY & ~(4'b0001 << M_TID)), 64'(0));
         if (gap) begin
            check({tag, " idle gap"}, 64'(M_TVALID), 64'(0));
            gap = 0;
         end
         shs = S_TVALID & S_TREADY;
         if (M_TVALID && M_TREADY) begin
            if (pi >= total) begin
               check({tag, " extra beat"}, 64'(pi), 64'(total - 1));
               fin = 1;
            end else begin
               e = expq[pi];
               exp_last = (bi == plen[e.port][e.pkt] - 1);
               check($sformatf("%s pkt%0d beat%0d tid", tag, pi, bi), 64'(M_TID), 64'(e.port));
               check($sformatf("%s pkt%0d beat%0d data", tag, pi, bi), 64'(M_TDATA),
                     64'(src_data(e.port, e.pkt, bi)));
               check($sformatf("%s pkt%0d beat%0d keep", tag, pi, bi), 64'(M_TKEEP),
                     64'(src_keep(e.port, bi)));
               check($sformatf("%s pkt%0d beat%0d last", tag, pi, bi), 64'(M_TLAST), 64'(exp_last));
               if (exp_last) begin
                  pi++; bi = 0; gap = 1;
                  if (pi == total) fin = 1;
               end else begin
                  bi++;
               end
            end
         end
         @(posedge ACLK); #1;
         for (int p = 0; p < 4; p++) begin
            if (shs[p]) begin
               if (cur_beat[p] == plen[p][cur_pkt[p]] - 1) begin
                  cur_pkt[p]++; cur_beat[p] = 0;
               end else begin
                  cur_beat[p]++;
               end
            end
         end
      end
      if (!fin) check({tag, " timeout packets seen"}, 64'(pi), 64'(total));
      S_TVALID = '0; S_TLAST = '0;
      @(negedge ACLK);
      if (gap) check({tag, " final idle gap"}, 64'(M_TVALID), 64'(0));
      check({tag, " pkt count"}, 64'(PKT_COUNT), 64'(total));
      check({tag, " pkt count 2b"}, 64'(w_COUNT), 64'(total % 4));
   endtask

   initial begin
      // Directed vectors: non-interleave, single port, backpressure, wrap, DONE.
      tbl.push_back(mk(4'b1001, 4'b1000, 8'hC0, 1, 4'h0, 0, 32'h0,     0, 2'd0, 4'b0000, 0, 0));
      tbl.push_back(mk(4'b1001, 4'b1000, 8'hC0, 1, 4'h0, 1, 32'h0C0,   0, 2'd0, 4'b0001, 0, 0));
      tbl.push_back(mk(4'b1000, 4'b1000, 8'hC0, 1, 4'h0, 0, 32'h0,     0, 2'd0, 4'b0001, 0, 0));
      tbl.push_back(mk(4'b1000, 4'b1000, 8'hC0, 1, 4'h0, 0, 32'h0,     0, 2'd0, 4'b0001, 0, 0));
      tbl.push_back(mk(4'b1001, 4'b1001, 8'hC1, 1, 4'h0, 1, 32'h0C1,   1, 2'd0, 4'b0001, 0, 0));
      tbl.push_back(mk(4'b1000, 4'b1000, 8'hC1, 1, 4'h0, 0, 32'h0,     0, 2'd0, 4'b0000, 1, 0));
      tbl.push_back(mk(4'b1000, 4'b1000, 8'hC1, 1, 4'h0, 1, 32'h3C1,   1, 2'd3, 4'b1000, 1, 0));
      tbl.push_back(mk(4'b0000, 4'b0000, 8'h00, 1, 4'h0, 0, 32'h0,     0, 2'd3, 4'b0000, 2, 0));
      tbl.push_back(mk(4'b0100, 4'b0000, 8'hA1, 1, 4'h0, 0, 32'h0,     0, 2'd3, 4'b0000, 2, 0));
      tbl.push_back(mk(4'b0100, 4'b0000, 8'hA1, 1, 4'h0, 1, 32'h2A1,   0, 2'd2, 4'b0100, 2, 0));
      tbl.push_back(mk(4'b0100, 4'b0000, 8'hA2, 1, 4'h0, 1, 32'h2A2,   0, 2'd2, 4'b0100, 2, 0));
      tbl.push_back(mk(4'b0100, 4'b0100, 8'hA3, 1, 4'h0, 1, 32'h2A3,   1, 2'd2, 4'b0100, 2, 0));
      tbl.push_back(mk(4'b0000, 4'b0000, 8'h00, 1, 4'h0, 0, 32'h0,     0, 2'd2, 4'b0000, 3, 0));
      tbl.push_back(mk(4'b0010, 4'b0000, 8'hB1, 1, 4'h0, 0, 32'h0,     0, 2'd2, 4'b0000, 3, 0));
      tbl.push_back(mk(4'b0010, 4'b0000, 8'hB1, 1, 4'h0, 1, 32'h1B1,   0, 2'd1, 4'b0010, 3, 0));
      tbl.push_back(mk(4'b0010, 4'b0000, 8'hB2, 0, 4'h0, 1, 32'h1B2,   0, 2'd1, 4'b0000, 3, 0));
      tbl.push_back(mk(4'b0010, 4'b0000, 8'hB2, 1, 4'h0, 1, 32'h1B2,   0, 2'd1, 4'b0010, 3, 0));
      tbl.push_back(mk(4'b0010, 4'b0000, 8'hB3, 0, 4'h0, 1, 32'h1B3,   0, 2'd1, 4'b0000, 3, 0));
      tbl.push_back(mk(4'b0010, 4'b0000, 8'hB3, 1, 4'h0, 1, 32'h1B3,   0, 2'd1, 4'b0010, 3, 0));
      tbl.push_back(mk(4'b0010, 4'b0010, 8'hB4, 0, 4'h0, 1, 32'h1B4,   1, 2'd1, 4'b0000, 3, 0));
      tbl.push_back(mk(4'b0010, 4'b0010, 8'hB4, 1, 4'h0, 1, 32'h1B4,   1, 2'd1, 4'b0010, 3, 0));
      tbl.push_back(mk(4'b0000, 4'b0000, 8'h00, 1, 4'h0, 0, 32'h0,     0, 2'd1, 4'b0000, 4, 0));
      tbl.push_back(mk(4'b0001, 4'b0001, 8'hE0, 1, 4'h0, 0, 32'h0,     0, 2'd1, 4'b0000, 4, 0));
      tbl.push_back(mk(4'b0001, 4'b0001, 8'hE0, 1, 4'h0, 1, 32'h0E0,   1, 2'd0, 4'b0001, 4, 0));
      tbl.push_back(mk(4'b0000, 4'b0000, 8'h00, 1, 4'h0, 0, 32'h0,     0, 2'd0, 4'b0000, 5, 0));
      tbl.push_back(mk(4'b0010, 4'b0000, 8'hF1, 1, 4'hF, 0, 32'h0,     0, 2'd0, 4'b0000, 5, 0));
      tbl.push_back(mk(4'b0010, 4'b0000, 8'hF1, 1, 4'hF, 1, 32'h1F1,   0, 2'd1, 4'b0010, 5, 0));
      tbl.push_back(mk(4'b0010, 4'b0010, 8'hF2, 1, 4'hF, 1, 32'h1F2,   1, 2'd1, 4'b0010, 5, 0));
      tbl.push_back(mk(4'b0000, 4'b0000, 8'h00, 1, 4'hF, 0, 32'h0,     0, 2'd1, 4'b0000, 6, 0));
      tbl.push_back(mk(4'b0000, 4'b0000, 8'h00, 1, 4'h0, 0, 32'h0,     0, 2'd1, 4'b0000, 6, 1));
      tbl.push_back(mk(4'b0100, 4'b0000, 8'h99, 1, 4'h0, 0, 32'h0,     0, 2'd1, 4'b0000, 6, 1));
      tbl.push_back(mk(4'b0100, 4'b0100, 8'h99, 1, 4'h0, 1, 32'h299,   1, 2'd2, 4'b0100, 6, 1));
      tbl.push_back(mk(4'b0000, 4'b0000, 8'h00, 1, 4'h0, 0, 32'h0,     0, 2'd2, 4'b0000, 7, 1));

      // Reset state with every input asking for service.
      ARESETN = 1'b0; S_TVALID = 4'hF; S_TLAST = '0; S_TDATA = '0; S_TKEEP = '0;
      S_DONE = 4'hF; M_TREADY = 1'b1;
      #3;
      check("reset tvalid", 64'(M_TVALID), 64'(0));
      check("reset tready", 64'(S_TREADY), 64'(0));
      check("reset tid",    64'(M_TID),    64'(0));
      check("reset count",  64'(PKT_COUNT), 64'(0));
      check("reset done",   64'(DONE),     64'(0));
      reset_dut();

      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge ACLK); #1;
         S_TVALID = tbl[i].vld; S_TLAST = tbl[i].lst; M_TREADY = tbl[i].mrdy; S_DONE = tbl[i].sdone;
         for (int p = 0; p < 4; p++) begin
            S_TDATA[p*32 +: 32] = {16'h0, 8'(p), tbl[i].d};
            S_TKEEP[p*4 +: 4]   = tbl[i].lst[p] ? 4'h7 : 4'hF;
         end
         @(negedge ACLK);
         check($sformatf("row%0d tvalid", i), 64'(M_TVALID), 64'(tbl[i].ev));
         check($sformatf("row%0d tid", i),    64'(M_TID),    64'(tbl[i].etid));
         check($sformatf("row%0d tready", i), 64'(S_TREADY), 64'(tbl[i].erdy));
         check($sformatf("row%0d count", i),  64'(PKT_COUNT), 64'(tbl[i].ecnt));
         check($sformatf("row%0d count2b", i), 64'(w_COUNT), 64'(tbl[i].ecnt % 4));
         check($sformatf("row%0d done", i),   64'(DONE),     64'(tbl[i].edone));
         check($sformatf("row%0d w view", i), 64'({w_TVALID, w_TID, w_TREADY, w_DONE}),
               64'({tbl[i].ev, tbl[i].etid, tbl[i].erdy, tbl[i].edone}));
         if (tbl[i].ev) begin
            check($sformatf("row%0d tdata", i), 64'(M_TDATA), 64'(tbl[i].ed));
            check($sformatf("row%0d tlast", i), 64'(M_TLAST), 64'(tbl[i].el));
            check($sformatf("row%0d tkeep", i), 64'(M_TKEEP), 64'(tbl[i].el ? 4'h7 : 4'hF));
            check($sformatf("row%0d w beat", i), 64'({w_TDATA, w_TKEEP, w_TLAST}),
                  64'({tbl[i].ed, tbl[i].el ? 4'h7 : 4'hF, tbl[i].el}));
         end
      end

      // Asynchronous reset in the middle of a packet from port 2.
      @(posedge ACLK); #1;
      S_TVALID = 4'b0100; S_TLAST = '0; S_DONE = '0; M_TREADY = 1'b1;
      S_TDATA[2*32 +: 32] = 32'h0000_02D0; S_TKEEP = 16'hFFFF;
      @(posedge ACLK); #1;
      @(negedge ACLK);
      check("areset pre tvalid", 64'(M_TVALID), 64'(1));
      check("areset pre done",   64'(DONE),     64'(1));
      #2 ARESETN = 1'b0;
      #1;
      check("areset tvalid", 64'(M_TVALID),  64'(0));
      check("areset tready", 64'(S_TREADY),  64'(0));
      check("areset count",  64'(PKT_COUNT), 64'(0));
      check("areset count2b", 64'(w_COUNT),  64'(0));
      check("areset done",   64'(DONE),      64'(0));
      #1 ARESETN = 1'b1;
      S_TVALID = 4'hF;
      @(negedge ACLK);
      check("areset first grant valid", 64'(M_TVALID), 64'(1));
      check("areset first grant tid",   64'(M_TID),    64'(0));
      check("areset first grant ready", 64'(S_TREADY), 64'(4'b0001));

      run_traffic(1'b0, "roundrobin");
      run_traffic(1'b1, "random1");
      run_traffic(1'b1, "random2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
